// File: rtl/spi_ctrl_pkg.sv
// Shared constants and state encoding for the SPI frame controller.
package spi_ctrl_pkg;

    localparam int unsigned DEF_DATA_BYTES = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned CMD_WRITE_BIT  = 7;

    // Controller states; explicit encoding keeps the state register readable in debug dumps.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_DATA   = 3'd2,
        ST_IGNORE = 3'd3,
        ST_DRAIN  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/sipo_shift_register.sv
// Serial-in parallel-out byte assembler, LSB received first.
module sipo_shift_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             output_valid
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] bit_cnt;

    // Shift right so the first bit ends up in out[0]; reset is synchronous because it
    // also carries the frame-start pulse, which is generated combinationally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out          <= '0;
            bit_cnt      <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            if (enable) begin
                out <= {serial_in, out[WIDTH-1:1]};
                if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                    bit_cnt      <= '0;
                    output_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_controller.sv
// SPI slave frame decoder: command byte, then little-endian words written to a register bank.
module spi_frame_controller
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = DEF_DATA_BYTES,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    mosi,
    input  logic                    cs_n,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic                    busy,
    output logic                    frame_error,
    output logic [15:0]             frame_count
);

    localparam int unsigned WORD_W = 8 * DATA_BYTES;
    localparam int unsigned BIDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned SET_W  = $clog2(SYNC_STAGES + 1);

    // Synchronizers and edge detection
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic [SET_W-1:0]       settle_cnt;
    logic                   armed;

    logic sck_s;
    logic mosi_s;
    logic cs_s;
    logic settled_c;
    logic sck_rise_c;
    logic cs_rise_c;
    logic start_edge_c;

    assign sck_s        = sck_sync[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync[SYNC_STAGES-1];
    assign cs_s         = cs_sync[SYNC_STAGES-1];
    assign settled_c    = (settle_cnt == SET_W'(SYNC_STAGES));
    assign sck_rise_c   = sck_s && !sck_prev;
    assign cs_rise_c    = cs_s && !cs_prev;
    // A falling edge only counts once cs_n has been seen high after reset, so a frame
    // already in flight at reset release is skipped.
    assign start_edge_c = armed && cs_prev && !cs_s;

    // Controller state
    ctrl_state_e           state;
    ctrl_state_e           state_n;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic [ADDR_WIDTH-1:0] addr_ptr_n;
    logic [BIDX_W-1:0]     byte_idx;
    logic [BIDX_W-1:0]     byte_idx_n;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_cnt_n;
    logic [WORD_W-1:0]     word_acc;
    logic [WORD_W-1:0]     word_acc_n;
    logic                  got_word;
    logic                  got_word_n;
    logic                  start_pend;
    logic                  start_pend_n;
    logic [ADDR_WIDTH-1:0] wr_addr_n;
    logic [WORD_W-1:0]     wr_data_n;
    logic                  wr_valid_n;
    logic                  busy_n;
    logic                  frame_error_n;
    logic [15:0]           frame_count_n;

    logic                  frame_start_c;
    logic                  do_start_c;
    logic                  active_c;
    logic                  sck_en_c;
    logic                  accept_c;
    logic                  pend_c;
    logic                  end_err_c;
    logic [WORD_W-1:0]     acc_c;
    logic                  sipo_rstn_c;

    logic [7:0]            byte_out;
    logic                  byte_valid;

    assign active_c    = (state == ST_CMD) || (state == ST_DATA) || (state == ST_IGNORE);
    assign sck_en_c    = sck_rise_c && !cs_s && active_c;
    assign accept_c    = wr_valid && wr_ready;
    assign sipo_rstn_c = !(rst || frame_start_c);

    // Bring the serial link into the clk domain and track edges and post-reset arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            sck_prev   <= 1'b0;
            cs_prev    <= 1'b1;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            sck_sync  <= SYNC_STAGES'({sck_sync, sck});
            mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
            cs_sync   <= SYNC_STAGES'({cs_sync, cs_n});
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            if (!settled_c) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (settled_c && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Byte assembly from qualified sck edges.
    sipo_shift_register #(
        .WIDTH (8)
    ) u_sipo (
        .clk          (clk),
        .rstn         (sipo_rstn_c),
        .enable       (sck_en_c),
        .serial_in    (mosi_s),
        .out          (byte_out),
        .output_valid (byte_valid)
    );

    // Controller register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_ptr    <= '0;
            byte_idx    <= '0;
            bit_cnt     <= '0;
            word_acc    <= '0;
            got_word    <= 1'b0;
            start_pend  <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            addr_ptr    <= addr_ptr_n;
            byte_idx    <= byte_idx_n;
            bit_cnt     <= bit_cnt_n;
            word_acc    <= word_acc_n;
            got_word    <= got_word_n;
            start_pend  <= start_pend_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            wr_valid    <= wr_valid_n;
            busy        <= busy_n;
            frame_error <= frame_error_n;
            frame_count <= frame_count_n;
        end
    end

    // Next-state and datapath: byte handling first, then frame-end bookkeeping.
    always_comb begin
        state_n       = state;
        addr_ptr_n    = addr_ptr;
        byte_idx_n    = byte_idx;
        bit_cnt_n     = bit_cnt;
        word_acc_n    = word_acc;
        got_word_n    = got_word;
        start_pend_n  = start_pend;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        wr_valid_n    = accept_c ? 1'b0 : wr_valid;
        busy_n        = busy;
        frame_error_n = frame_error;
        frame_count_n = frame_count;
        frame_start_c = 1'b0;
        do_start_c    = 1'b0;
        pend_c        = 1'b0;
        end_err_c     = 1'b0;
        acc_c         = word_acc;

        case (state)
            ST_IDLE: begin
                if (start_edge_c) begin
                    do_start_c = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Remember a frame start seen while the last word waits; act on it after the handshake.
                pend_c       = start_pend || start_edge_c;
                start_pend_n = pend_c && !cs_s;
                if (accept_c) begin
                    start_pend_n = 1'b0;
                    if (pend_c && !cs_s) begin
                        do_start_c = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_CMD, ST_DATA, ST_IGNORE: begin
                if (sck_en_c) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                end

                if (byte_valid) begin
                    if (state == ST_CMD) begin
                        addr_ptr_n = byte_out[ADDR_WIDTH-1:0];
                        byte_idx_n = '0;
                        state_n    = byte_out[CMD_WRITE_BIT] ? ST_DATA : ST_IGNORE;
                    end else if (state == ST_DATA) begin
                        for (int b = 0; b < int'(DATA_BYTES); b++) begin
                            if (byte_idx == BIDX_W'(b)) begin
                                acc_c[8*b +: 8] = byte_out;
                            end
                        end
                        word_acc_n = acc_c;
                        if (byte_idx == BIDX_W'(DATA_BYTES - 1)) begin
                            byte_idx_n = '0;
                            got_word_n = 1'b1;
                            addr_ptr_n = addr_ptr + ADDR_WIDTH'(1);
                            if (wr_valid && !wr_ready) begin
                                // Overrun: keep the pending word, drop this one.
                                frame_error_n = 1'b1;
                            end else begin
                                wr_valid_n = 1'b1;
                                wr_data_n  = acc_c;
                                wr_addr_n  = addr_ptr;
                            end
                        end else begin
                            byte_idx_n = byte_idx + BIDX_W'(1);
                        end
                    end
                end

                if (cs_rise_c) begin
                    // Partial byte, partial word or a bare command byte makes the frame bad.
                    end_err_c = frame_error_n;
                    if (state_n == ST_CMD) begin
                        end_err_c = 1'b1;
                    end else if (state_n == ST_DATA &&
                                 (bit_cnt_n != 3'd0 || byte_idx_n != '0 || !got_word_n)) begin
                        end_err_c = 1'b1;
                    end
                    frame_error_n = end_err_c;
                    if (!end_err_c) begin
                        frame_count_n = frame_count + 16'd1;
                    end
                    busy_n  = 1'b0;
                    state_n = wr_valid_n ? ST_DRAIN : ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (do_start_c) begin
            frame_start_c = 1'b1;
            state_n       = ST_CMD;
            frame_error_n = 1'b0;
            busy_n        = 1'b1;
            bit_cnt_n     = '0;
            byte_idx_n    = '0;
            got_word_n    = 1'b0;
            start_pend_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_frame_controller.sv
// Randomized scoreboard bench for spi_frame_controller with a frame-level reference model.
module tb_spi_frame_controller;

    localparam int DB = 4;
    localparam int AW = 7;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [8*DB-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            sck;
    logic            mosi;
    logic            cs_n;
    logic [AW-1:0]   wr_addr;
    logic [8*DB-1:0] wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            busy;
    logic            frame_error;
    logic [15:0]     frame_count;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    int          ready_mode = 1;   // 0 random, 1 always ready, 2 held low
    bit          saw_valid = 1'b0;
    bit          exp_err = 1'b0;
    logic [15:0] exp_count = 16'd0;
    logic [7:0]  fb[$];

    bit              pv = 1'b0;
    bit              pr = 1'b0;
    logic [AW-1:0]   pa;
    logic [8*DB-1:0] pd;

    spi_frame_controller #(
        .DATA_BYTES  (DB),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .frame_error (frame_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready driver: changes just after the rising edge so the monitor sees a stable value.
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       wr_ready = ($urandom_range(0, 3) != 0);
                1:       wr_ready = 1'b1;
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (wr_valid) saw_valid = 1'b1;
                if (pv && !pr) begin
                    check("hold_valid", 64'(wr_valid), 64'd1);
                    check("hold_addr", 64'(wr_addr), 64'(pa));
                    check("hold_data", 64'(wr_data), 64'(pd));
                end
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(e.addr));
                        check("wr_data", 64'(wr_data), 64'(e.data));
                    end
                end
                pv = wr_valid;
                pr = wr_ready;
                pa = wr_addr;
                pd = wr_data;
            end
        end
    end

    // Frame-level model: decide writes, error and count from the byte list alone.
    task automatic model_frame(input logic [7:0] f[$], input int extra, input bit hold);
        bit              err;
        int              nwords;
        int              rem;
        logic [AW-1:0]   a;
        logic [8*DB-1:0] w;
        wr_t             item;
        err = 1'b0;
        if (f.size() == 0) begin
            err = 1'b1;
        end else if (f[0][7]) begin
            nwords = (f.size() - 1) / DB;
            rem    = (f.size() - 1) % DB;
            a      = f[0][AW-1:0];
            for (int i = 0; i < nwords; i++) begin
                w = '0;
                for (int b = 0; b < DB; b++) w[8*b +: 8] = f[1 + DB*i + b];
                if (hold && i > 0) begin
                    err = 1'b1;
                end else begin
                    item.addr = a;
                    item.data = w;
                    exp_q.push_back(item);
                end
                a = a + AW'(1);
            end
            if (nwords == 0 || rem != 0 || extra != 0) err = 1'b1;
        end
        exp_err = err;
        if (!err) exp_count = exp_count + 16'd1;
    endtask

    task automatic wait_no_valid();
        int k = 0;
        while (wr_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (wr_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: wr_valid still %0d after %0d cycles", wr_valid, k);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || wr_valid) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // One serial bit; optional check of the write-valid latency after the final edge.
    task automatic send_bit(input logic b, input bit tcheck);
        @(negedge clk);
        mosi = b;
        repeat (3) @(negedge clk);
        sck = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (tcheck && k == 3) check("valid_not_early", 64'(wr_valid), 64'd0);
            if (tcheck && k == 4) check("valid_rise", 64'(wr_valid), 64'd1);
        end
        sck = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int extra, input bit tcheck);
        wait_no_valid();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check("start_err_clear", 64'(frame_error), 64'd0);
        check("busy_on", 64'(busy), 64'd1);
        for (int i = 0; i < f.size(); i++)
            for (int j = 0; j < 8; j++)
                send_bit(f[i][j], tcheck && (i == f.size() - 1) && (j == 7));
        for (int j = 0; j < extra; j++) send_bit(1'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int extra, input bit hold,
                             input bit tcheck, input string tag);
        model_frame(f, extra, hold);
        send_frame(f, extra, tcheck);
        check({tag, "_err"}, 64'(frame_error), 64'(exp_err));
        check({tag, "_count"}, 64'(frame_count), 64'(exp_count));
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(wr_valid), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        check("rst_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(frame_error), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single word write with latency check.
        ready_mode = 1;
        fb = {8'h85, 8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(fb, 0, 1'b0, 1'b1, "single");
        wait_drain();

        // Two-word burst wrapping the address.
        fb = {8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame(fb, 0, 1'b0, 1'b0, "wrap");
        wait_drain();

        // Same burst with the register bank stalled: second word overruns.
        ready_mode = 2;
        run_frame(fb, 0, 1'b1, 1'b0, "overrun");
        check("overrun_pending", 64'(wr_valid), 64'd1);
        check("overrun_addr", 64'(wr_addr), 64'h7F);
        check("overrun_data", 64'(wr_data), 64'h04030201);
        ready_mode = 1;
        wait_drain();

        // Frame ends after 13 bits.
        fb = {8'h81};
        run_frame(fb, 5, 1'b0, 1'b0, "partial");

        // Read command: ignored but counted; its start also clears the previous error.
        fb = {8'h05, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_frame(fb, 0, 1'b0, 1'b0, "ignore");
        wait_drain();

        // Reset in the middle of a write frame.
        fb = {8'h81, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        saw_valid = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 20; k++) send_bit(fb[k/8][k%8], 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(wr_valid), 64'd0);
        check("midrst_addr", 64'(wr_addr), 64'd0);
        check("midrst_data", 64'(wr_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(frame_error), 64'd0);
        check("midrst_count", 64'(frame_count), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 20; k < 40; k++) send_bit(fb[k/8][k%8], 1'b0);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_valid", 64'(saw_valid), 64'd0);
        check("midrst_count_after", 64'(frame_count), 64'd0);
        check("midrst_busy_after", 64'(busy), 64'd0);
        exp_count = 16'd0;

        // Randomized frames with random backpressure.
        ready_mode = 0;
        for (int n = 0; n < 20; n++) begin
            int   ndata;
            int   extra;
            logic [7:0] cmd;
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'h7E + 7'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) cmd[7] = 1'b1;
            ndata = $urandom_range(0, 9);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            fb = {cmd};
            for (int i = 0; i < ndata; i++) fb.push_back(8'($urandom));
            run_frame(fb, extra, 1'b0, 1'b0, "rand");
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
